// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer with staggered downstream reset release
// Optional build macro: PLL_LOCK_GLITCH_FILTER_EN (RUN-state lock-loss glitch filter)
module pll_lock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned RELEASE_GAP         = 8
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       video_reset_n,
    output logic       core_reset_n,
    output logic       lock_ok,
    output logic       lock_lost,
    output logic [7:0] retry_count
);

    // Shared counter is sized for the largest interval it must reach.
    localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CD = (LOCK_STABLE_CYCLES > RELEASE_GAP) ?
                                     LOCK_STABLE_CYCLES : RELEASE_GAP;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int          CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_CNT   = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    // Four consecutive low samples are needed before RUN declares loss.
    localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(3);
`else
    // The first low sample in RUN is already a loss.
    localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(0);
`endif

    localparam logic [2:0] ST_PLL_RESET = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    logic             sync1_q;
    logic             lk_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic             pll_rst_q, video_q, core_q, lock_ok_q, lock_lost_q;
    logic             lock_lost_d;

    // Two-flop synchroniser for the asynchronous PLL locked output.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            lk_s_q  <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lk_s_q  <= sync1_q;
        end
    end

    // Next-state, shared counter and retry bookkeeping; counter clears on every state entry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a simultaneous timeout.
                if (lk_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_PLL_RESET;
                    cnt_d   = '0;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                end
            end
            ST_STABLE: begin
                if (!lk_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_CNT) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                // Loss while releasing restarts the PLL quietly, without a lock_lost pulse.
                if (!lk_s_q) begin
                    state_d = ST_PLL_RESET;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // In RUN the counter tracks consecutive low lock samples.
                if (lk_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == FILT_LAST) begin
                    state_d     = ST_PLL_RESET;
                    cnt_d       = '0;
                    lock_lost_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_PLL_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            pll_rst_q   <= 1'b1;
            video_q     <= 1'b0;
            core_q      <= 1'b0;
            lock_ok_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == ST_PLL_RESET);
            video_q     <= (state_d == ST_RELEASE) || (state_d == ST_RUN);
            core_q      <= (state_d == ST_RUN);
            lock_ok_q   <= (state_d == ST_RUN);
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign video_reset_n = video_q;
    assign core_reset_n  = core_q;
    assign lock_ok       = lock_ok_q;
    assign lock_lost     = lock_lost_q;
    assign retry_count   = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    localparam int RSTC = 4;
    localparam int TMO  = 50;
    localparam int STB  = 10;
    localparam int GAP  = 3;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 1;
`endif
    // pll_locked fall to lock_lost: two synchroniser cycles plus the filter samples.
    localparam int LOSS_LAT = 2 + FILT;
    // pll_locked rise (in WAIT_LOCK) to video release, from the power-up timeline (20 -> 34).
    localparam int VID_LAT  = 14;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, video_reset_n, core_reset_n, lock_ok, lock_lost;
    logic [7:0] retry_count;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (RSTC),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .LOCK_STABLE_CYCLES (STB),
        .RELEASE_GAP        (GAP)
    ) dut (
        .clk_74a      (clk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .video_reset_n(video_reset_n),
        .core_reset_n (core_reset_n),
        .lock_ok      (lock_ok),
        .lock_lost    (lock_lost),
        .retry_count  (retry_count)
    );

    typedef enum int {P_RST, P_WAIT, P_STAB, P_REL, P_RUN} phase_t;

    phase_t m_ph;
    int     m_age, m_low, m_retry;
    bit     m_lost, m_s1, m_lk;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ph = P_RST; m_age = 0; m_low = 0; m_retry = 0;
        m_lost = 1'b0; m_s1 = 1'b0; m_lk = 1'b0;
    endtask

    // Phase-level reference: each phase lasts a number of cycles measured by its age.
    task automatic model_edge(input bit din);
        phase_t np;
        np = m_ph;
        m_lost = 1'b0;
        case (m_ph)
            P_RST:  if (m_age + 1 == RSTC) np = P_WAIT;
            P_WAIT: if (m_lk) np = P_STAB;
                    else if (m_age == TMO) begin
                        np = P_RST;
                        if (m_retry < 255) m_retry++;
                    end
            P_STAB: if (!m_lk) np = P_WAIT; else if (m_age == STB) np = P_REL;
            P_REL:  if (!m_lk) np = P_RST; else if (m_age + 1 == GAP) np = P_RUN;
            P_RUN: begin
                m_low = m_lk ? 0 : m_low + 1;
                if (m_low == FILT) begin
                    np = P_RST;
                    m_lost = 1'b1;
                end
            end
            default: np = P_RST;
        endcase
        if (np != m_ph) begin
            m_age = 0;
            m_low = 0;
        end else begin
            m_age++;
        end
        m_ph = np;
        m_lk = m_s1;
        m_s1 = din;
    endtask

    task automatic check_outputs();
        chk("pll_rst",       32'(pll_rst),       32'(m_ph == P_RST));
        chk("video_reset_n", 32'(video_reset_n), 32'(m_ph == P_REL || m_ph == P_RUN));
        chk("core_reset_n",  32'(core_reset_n),  32'(m_ph == P_RUN));
        chk("lock_ok",       32'(lock_ok),       32'(m_ph == P_RUN));
        chk("lock_lost",     32'(lock_lost),     32'(m_lost));
        chk("retry_count",   32'(retry_count),   32'(m_retry));
        chk("inv_core_after_video", 32'(core_reset_n & ~video_reset_n), 32'd0);
        chk("inv_pll_rst_released", 32'(pll_rst & (video_reset_n | core_reset_n)), 32'd0);
    endtask

    // din is the pll_locked level during the current cycle; outputs are checked 1 ns after the edge.
    task automatic tick(input bit din);
        pll_locked = din;
        @(posedge clk);
        model_edge(din);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic run_until(input phase_t p, input int budget, input bit din);
        int n;
        n = 0;
        while (m_ph != p && n < budget) begin
            tick(din);
            n++;
        end
        chk("reach_phase_within_budget", 32'(m_ph == p), 32'd1);
    endtask

    initial begin
        int f, g, lvl, len;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        #1;
        check_outputs();
        chk("reset_pll_rst", 32'(pll_rst), 32'd1);
        chk("reset_retry",   32'(retry_count), 32'd0);

        // Power-up timeline: lock arrives at cycle 20.
        for (int c = 0; c < 45; c++) begin
            tick(c >= 20);
            case (cyc)
                3:  chk("pu_pll_rst_c3",  32'(pll_rst), 32'd1);
                4:  chk("pu_pll_rst_c4",  32'(pll_rst), 32'd0);
                33: chk("pu_video_c33",   32'(video_reset_n), 32'd0);
                34: chk("pu_video_c34",   32'(video_reset_n), 32'd1);
                36: chk("pu_core_c36",    32'(core_reset_n), 32'd0);
                37: begin
                    chk("pu_core_c37",    32'(core_reset_n), 32'd1);
                    chk("pu_lock_ok_c37", 32'(lock_ok), 32'd1);
                    chk("pu_retry_c37",   32'(retry_count), 32'd0);
                end
                default: ;
            endcase
        end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
        // Three low cycles are filtered out in RUN.
        for (int i = 0; i < 15; i++) begin
            tick(!(i < 3));
            chk("filt_short_lock_ok", 32'(lock_ok), 32'd1);
        end
`endif

        // Lock loss in RUN.
        f = cyc;
        for (int i = 0; i < 12; i++) begin
            tick(i >= FILT);
            if (cyc == f + LOSS_LAT - 1) begin
                chk("loss_pre_lock_ok", 32'(lock_ok), 32'd1);
                chk("loss_pre_lost",    32'(lock_lost), 32'd0);
            end
            if (cyc == f + LOSS_LAT) begin
                chk("loss_lost",   32'(lock_lost), 32'd1);
                chk("loss_video",  32'(video_reset_n), 32'd0);
                chk("loss_core",   32'(core_reset_n), 32'd0);
                chk("loss_pllrst", 32'(pll_rst), 32'd1);
            end
            if (cyc == f + LOSS_LAT + 1) chk("loss_lost_one_cycle", 32'(lock_lost), 32'd0);
        end
        run_until(P_RUN, 200, 1'b1);

        // Stability glitch six cycles into STABLE.
        tick(1'b0); tick(1'b0);
        run_until(P_STAB, 200, 1'b1);
        repeat (4) tick(1'b1);
        g = cyc;
        tick(1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            if (cyc == g + 3) chk("glitch_back_to_wait", 32'(m_ph == P_WAIT), 32'd1);
            if (cyc == g + VID_LAT) chk("glitch_video_pre", 32'(video_reset_n), 32'd0);
            if (cyc == g + VID_LAT + 1) chk("glitch_video_rel", 32'(video_reset_n), 32'd1);
        end

        // Randomised lock waveform against the reference model.
        lvl = 1;
        for (int s = 0; s < 120; s++) begin
            len = $urandom_range(1, 40);
            lvl = ($urandom_range(0, 3) == 0) ? lvl : 1 - lvl;
            for (int i = 0; i < len; i++) tick(lvl[0]);
        end

        // No lock: retries every RSTC+TMO+1 cycles, then saturation.
        run_until(P_RST, 200, 1'b0);
        f = m_retry;
        repeat (RSTC) tick(1'b0);
        for (int r = 1; r <= 3; r++) begin
            repeat (TMO + 1) tick(1'b0);
            chk("noloc_retry_inc", 32'(retry_count), 32'((f + r > 255) ? 255 : f + r));
            repeat (RSTC) tick(1'b0);
        end
        repeat (300 * (RSTC + TMO + 1)) tick(1'b0);
        chk("retry_saturated", 32'(retry_count), 32'd255);

        // Asynchronous reset between video and core release.
        run_until(P_REL, 300, 1'b1);
        chk("mid_rel_video", 32'(video_reset_n), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pll_rst", 32'(pll_rst), 32'd1);
        chk("arst_video",   32'(video_reset_n), 32'd0);
        chk("arst_core",    32'(core_reset_n), 32'd0);
        chk("arst_lock_ok", 32'(lock_ok), 32'd0);
        chk("arst_lost",    32'(lock_lost), 32'd0);
        chk("arst_retry",   32'(retry_count), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("arst_core_held", 32'(core_reset_n), 32'd0);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        #1;
        check_outputs();
        run_until(P_RUN, 200, 1'b1);
        repeat (5) tick(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
